// File: rtl/dmem_responder.sv
// Multi-cycle byte-addressed little-endian data memory with valid/ready request and
// response channels, programmable access latency and illegal-request reporting.
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [63:0] write_data,
  input  logic [3:0]  xfer_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] read_data,
  output logic        resp_err
);

  localparam int          AW      = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  LAT     = 4'(LATENCY);
  localparam logic [64:0] DEPTH65 = 65'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] cap_addr;
  logic [63:0] cap_wdata;
  logic        cap_we;
  logic        cap_re;
  logic [3:0]  cap_size;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [63:0] cur_addr;
  logic [63:0] cur_wdata;
  logic        cur_we;
  logic        cur_re;
  logic [3:0]  cur_size;
  logic        size_ok;
  logic        align_ok;
  logic        range_ok;
  logic        legal;
  logic        commit;
  logic [63:0] load_val;
  logic [63:0] rdata_next;

  // With zero latency the commit happens on the accept edge, so the live bus is the source.
  assign cur_addr  = (state == IDLE) ? address      : cap_addr;
  assign cur_wdata = (state == IDLE) ? write_data   : cap_wdata;
  assign cur_we    = (state == IDLE) ? write_enable : cap_we;
  assign cur_re    = (state == IDLE) ? read_enable  : cap_re;
  assign cur_size  = (state == IDLE) ? xfer_size    : cap_size;

  assign size_ok  = (cur_size == 4'd1) || (cur_size == 4'd2) ||
                    (cur_size == 4'd4) || (cur_size == 4'd8);
  assign align_ok = (cur_addr & {60'b0, cur_size - 4'd1}) == 64'b0;
  // 65-bit sum so addresses near 2^64 cannot wrap into range
  assign range_ok = ({1'b0, cur_addr} + {61'b0, cur_size}) <= DEPTH65;
  assign legal    = size_ok && align_ok && range_ok && !(cur_we && cur_re);

  assign commit = reset &&
                  (((state == IDLE) && req_valid && (LAT == 4'd0)) ||
                   ((state == WAIT) && (cnt == 4'd1)));

  always_comb begin
    load_val = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < cur_size)
        load_val[8*i +: 8] = mem[cur_addr[AW-1:0] + AW'(i)];
    end
  end

  assign rdata_next = (legal && cur_re) ? load_val : 64'b0;

  // Storage deliberately has no reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (commit && legal && cur_we) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < cur_size)
          mem[cur_addr[AW-1:0] + AW'(i)] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_we     <= 1'b0;
      cap_re     <= 1'b0;
      cap_size   <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      read_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_addr  <= address;
            cap_wdata <= write_data;
            cap_we    <= write_enable;
            cap_re    <= read_enable;
            cap_size  <= xfer_size;
            req_ready <= 1'b0;
            if (LAT == 4'd0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= !legal;
              read_data  <= rdata_next;
            end else begin
              state <= WAIT;
              cnt   <= LAT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state      <= RESP;
            cnt        <= '0;
            resp_valid <= 1'b1;
            resp_err   <= !legal;
            read_data  <= rdata_next;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            read_data  <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, backpressure and reset
// sequences, a zero-latency instance, and randomized traffic against a byte-array model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, write_enable, read_enable;
  logic [63:0] address, write_data, read_data;
  logic [3:0]  xfer_size;
  logic        resp_valid, resp_ready, resp_err;

  logic        z_req_valid, z_req_ready, z_we, z_re;
  logic [63:0] z_addr, z_wdata, z_rdata;
  logic [3:0]  z_size;
  logic        z_resp_valid, z_resp_ready, z_err;

  int checks = 0;
  int failures = 0;

  logic [7:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .address(address), .write_enable(write_enable), .read_enable(read_enable),
    .write_data(write_data), .xfer_size(xfer_size), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .read_data(read_data), .resp_err(resp_err));

  dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .address(z_addr), .write_enable(z_we), .read_enable(z_re),
    .write_data(z_wdata), .xfer_size(z_size), .resp_valid(z_resp_valid),
    .resp_ready(z_resp_ready), .read_data(z_rdata), .resp_err(z_err));

  typedef struct {
    logic        we;
    logic        re;
    logic [63:0] addr;
    logic [3:0]  size;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit legal_ref(input logic we, input logic re,
                                   input logic [63:0] a, input logic [3:0] sz);
    longint unsigned n  = longint'(sz);
    longint unsigned ua = a;
    if (!(sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8)) return 1'b0;
    if (ua % n != 0) return 1'b0;
    if (ua > longint'(DEPTH) - n) return 1'b0;
    if (we && re) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [3:0] sz);
    logic [63:0] v = '0;
    for (int i = 0; i < int'(sz); i++) v[8*i +: 8] = ref_mem[int'(a[31:0]) + i];
    return v;
  endfunction

  // Called one time unit after a clock edge with the DUT idle; returns the same way.
  task automatic xact(input logic we, input logic re, input logic [63:0] a,
                      input logic [3:0] sz, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er);
    int n = 0;
    int lat;
    req_valid = 1'b1; write_enable = we; read_enable = re;
    address = a; xfer_size = sz; write_data = wd; resp_ready = 1'b1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    address = {$urandom, $urandom}; write_data = {$urandom, $urandom};
    xfer_size = 4'($urandom); write_enable = ~we; read_enable = ~re;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = read_data;
    er = resp_err;
    chk("latency", 64'(lat), 64'(LAT + 1));
    @(posedge clk); #1;
    chk("idle_return", {62'b0, req_ready, resp_valid}, 64'h2);
  endtask

  task automatic xact0(input logic we, input logic re, input logic [63:0] a,
                       input logic [3:0] sz, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er);
    int lat;
    z_req_valid = 1'b1; z_we = we; z_re = re; z_addr = a; z_size = sz; z_wdata = wd;
    z_resp_ready = 1'b1;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_addr = {$urandom, $urandom}; z_wdata = {$urandom, $urandom};
    lat = 1;
    while (!z_resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = z_rdata;
    er = z_err;
    chk("lat0_latency", 64'(lat), 64'd1);
    @(posedge clk); #1;
    chk("lat0_idle_return", {62'b0, z_req_ready, z_resp_valid}, 64'h2);
  endtask

  initial begin
    logic [63:0] rd, exp_rd, a, wd, exp20, exp10;
    logic        er, we, re, lg;
    logic [3:0]  sz;
    int          n;

    reset = 1'b0;
    req_valid = 0; write_enable = 0; read_enable = 0; address = 0;
    write_data = 0; xfer_size = 0; resp_ready = 0;
    z_req_valid = 0; z_we = 0; z_re = 0; z_addr = 0; z_wdata = 0; z_size = 0;
    z_resp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {63'b0, req_ready}, 64'd1);
    chk("reset_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("reset_read_data", read_data, 64'd0);
    chk("reset_resp_err", {63'b0, resp_err}, 64'd0);
    chk("reset0_resp_valid", {63'b0, z_resp_valid}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = '{1'b1, 1'b0, 64'h10, 4'd8, 64'h1122334455667788, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b1, 64'h10, 4'd8, 64'h0, 1'b0, 64'h1122334455667788};
    vecs[2]  = '{1'b1, 1'b0, 64'h13, 4'd1, 64'hFFFFFFFFFFFFFFAB, 1'b0, 64'h0};
    vecs[3]  = '{1'b0, 1'b1, 64'h10, 4'd8, 64'h0, 1'b0, 64'h11223344AB667788};
    vecs[4]  = '{1'b0, 1'b1, 64'h12, 4'd2, 64'h0, 1'b0, 64'h000000000000AB66};
    vecs[5]  = '{1'b1, 1'b0, 64'h16, 4'd4, 64'hCAFEBABE, 1'b1, 64'h0};
    vecs[6]  = '{1'b0, 1'b1, 64'h14, 4'd4, 64'h0, 1'b0, 64'h11223344};
    vecs[7]  = '{1'b0, 1'b1, 64'(DEPTH - 4), 4'd8, 64'h0, 1'b1, 64'h0};
    vecs[8]  = '{1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF8, 4'd8, 64'h0, 1'b1, 64'h0};
    vecs[9]  = '{1'b0, 1'b1, 64'h10, 4'd3, 64'h0, 1'b1, 64'h0};
    vecs[10] = '{1'b1, 1'b1, 64'h10, 4'd8, 64'h0, 1'b1, 64'h0};
    vecs[11] = '{1'b0, 1'b1, 64'h10, 4'd8, 64'h0, 1'b0, 64'h11223344AB667788};
    vecs[12] = '{1'b0, 1'b0, 64'h10, 4'd8, 64'h5555, 1'b0, 64'h0};
    vecs[13] = '{1'b1, 1'b0, 64'(DEPTH - 8), 4'd8, 64'h0102030405060708, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 1'b1, 64'(DEPTH - 8), 4'd8, 64'h0, 1'b0, 64'h0102030405060708};
    vecs[15] = '{1'b0, 1'b1, 64'h11, 4'd2, 64'h0, 1'b1, 64'h0};
    vecs[16] = '{1'b0, 1'b1, 64'(DEPTH), 4'd1, 64'h0, 1'b1, 64'h0};
    vecs[17] = '{1'b1, 1'b0, 64'h12, 4'd2, 64'hFFFF1234, 1'b0, 64'h0};
    vecs[18] = '{1'b0, 1'b1, 64'h10, 4'd4, 64'h0, 1'b0, 64'h12347788};
    vecs[19] = '{1'b0, 1'b1, 64'(DEPTH - 1), 4'd1, 64'h0, 1'b0, 64'h01};

    for (int i = 0; i < 20; i++) begin
      xact(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_read_data", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_resp_err", i), {63'b0, er}, {63'b0, vecs[i].exp_err});
    end

    // Backpressure: response must hold while resp_ready is low; stray requests ignored.
    exp10 = 64'h1122334412347788;
    req_valid = 1'b1; write_enable = 0; read_enable = 1; address = 64'h10;
    xfer_size = 4'd8; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; write_enable = 1; read_enable = 0; write_data = 64'h0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int k = 0; k < 5; k++) begin
      chk("bp_resp_valid", {63'b0, resp_valid}, 64'd1);
      chk("bp_read_data", read_data, exp10);
      chk("bp_resp_err", {63'b0, resp_err}, 64'd0);
      chk("bp_req_ready", {63'b0, req_ready}, 64'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {62'b0, req_ready, resp_valid}, 64'h2);
    chk("bp_release_data", read_data, 64'd0);
    xact(1'b0, 1'b1, 64'h10, 4'd8, 64'h0, rd, er);
    chk("bp_no_stray_write", rd, exp10);

    // Zero-latency instance.
    xact0(1'b1, 1'b0, 64'h40, 4'd8, 64'hAAAA5555DEADBEEF, rd, er);
    chk("lat0_store_err", {63'b0, er}, 64'd0);
    xact0(1'b0, 1'b1, 64'h40, 4'd8, 64'h0, rd, er);
    chk("lat0_load", rd, 64'hAAAA5555DEADBEEF);
    xact0(1'b1, 1'b1, 64'h40, 4'd8, 64'h0, rd, er);
    chk("lat0_both_err", {63'b0, er}, 64'd1);
    chk("lat0_both_data", rd, 64'd0);
    xact0(1'b0, 1'b1, 64'h40, 4'd8, 64'h0, rd, er);
    chk("lat0_no_write", rd, 64'hAAAA5555DEADBEEF);

    // Fill the whole array so the model knows every byte.
    for (int k = 0; k < DEPTH / 8; k++) begin
      wd = {$urandom, $urandom};
      xact(1'b1, 1'b0, 64'(8 * k), 4'd8, wd, rd, er);
      chk("fill_err", {63'b0, er}, 64'd0);
      for (int b = 0; b < 8; b++) ref_mem[8 * k + b] = wd[8*b +: 8];
    end

    // Reset during WAIT aborts the store.
    exp20 = ref_load(64'h20, 4'd2);
    req_valid = 1'b1; write_enable = 1; read_enable = 0; address = 64'h20;
    xfer_size = 4'd2; write_data = 64'hDEAD; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    chk("rst_read_data", read_data, 64'd0);
    chk("rst_resp_err", {63'b0, resp_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 1'b1, 64'h20, 4'd2, 64'h0, rd, er);
    chk("rst_aborted_store", rd, exp20);

    // Randomized traffic against the byte-array model.
    for (int t = 0; t < 300; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'(1 << $urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       a = {$urandom, $urandom};
        1:       a = 64'(DEPTH - int'($urandom_range(0, 16)));
        2:       a = 64'($urandom_range(0, 63));
        default: a = 64'($urandom_range(0, DEPTH - 1)) & ~64'(sz - 4'd1);
      endcase
      case ($urandom_range(0, 9))
        0:             begin we = 1; re = 1; end
        1:             begin we = 0; re = 0; end
        2, 3, 4, 5:    begin we = 0; re = 1; end
        default:       begin we = 1; re = 0; end
      endcase
      wd = {$urandom, $urandom};
      lg = legal_ref(we, re, a, sz);
      exp_rd = (lg && re) ? ref_load(a, sz) : 64'd0;
      xact(we, re, a, sz, wd, rd, er);
      chk($sformatf("rand%0d_read_data", t), rd, exp_rd);
      chk($sformatf("rand%0d_resp_err", t), {63'b0, er}, {63'b0, !lg});
      if (lg && we)
        for (int b = 0; b < int'(sz); b++) ref_mem[int'(a[31:0]) + b] = wd[8*b +: 8];
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
